// File: rtl/bias_add_pkg.sv
// Shared constants and types for the bias add / saturate / ReLU block.
// Holds the lane width, saturation limits and the pass FSM states.
package bias_add_pkg;

    localparam int DW = 18;

    localparam logic [DW-1:0] SAT_MAX = 18'h1FFFF;
    localparam logic [DW-1:0] SAT_MIN = 18'h20000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/bias_sat_lane.sv
// One lane of saturate + optional ReLU applied to a registered DW+1 sum.
// Ports: sum_i (DW+1 signed sum), res_o (DW-bit saturated result).
module bias_sat_lane
    import bias_add_pkg::*;
#(
    parameter int DW   = bias_add_pkg::DW,
    parameter int RELU = 1
) (
    input  logic [DW:0]   sum_i,
    output logic [DW-1:0] res_o
);

    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic [DW-1:0] sat;

    generate
        if (DW == bias_add_pkg::DW) begin : g_pkg
            assign hi = SAT_MAX;
            assign lo = SAT_MIN;
        end else begin : g_gen
            assign hi = {1'b0, {(DW-1){1'b1}}};
            assign lo = {1'b1, {(DW-1){1'b0}}};
        end
    endgenerate

    // The two top bits of the sum differ exactly when it left DW-bit range;
    // the extra sign bit tells which way.
    always_comb begin
        sat = sum_i[DW-1:0];
        if (sum_i[DW] != sum_i[DW-1]) begin
            sat = sum_i[DW] ? lo : hi;
        end
        res_o = sat;
        if ((RELU != 0) && sat[DW-1]) begin
            res_o = '0;
        end
    end

endmodule

// File: rtl/bias_add_relu.sv
// Adds the selected bias vector to each accumulator beat, saturates, ReLUs.
// Ports: start/busy/done pass control, acc_* input stream, bias_q/bias_sel
// bias ROM interface, out_* output stream (2-stage valid/ready pipeline).
module bias_add_relu
    import bias_add_pkg::*;
#(
    parameter int N_adder_tree  = 16,
    parameter int DW            = bias_add_pkg::DW,
    parameter int PIX_PER_GROUP = 196,
    parameter int N_GROUPS      = 2,
    parameter int RELU          = 1,
    localparam int SW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       acc_valid,
    output logic                       acc_ready,
    input  logic [N_adder_tree*DW-1:0] acc_data,
    input  logic [N_adder_tree*DW-1:0] bias_q,
    output logic [SW-1:0]              bias_sel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_adder_tree*DW-1:0] out_data,
    output logic                       busy,
    output logic                       done
);

    localparam int PW = (PIX_PER_GROUP > 1) ? $clog2(PIX_PER_GROUP) : 1;
    localparam int SUMW = DW + 1;
    localparam int VW = N_adder_tree * DW;
    localparam int SVW = N_adder_tree * SUMW;
    localparam logic [PW-1:0] PIX_LAST = PW'(PIX_PER_GROUP - 1);
    localparam logic [SW-1:0] GRP_LAST = SW'(N_GROUPS - 1);

    state_e state_q, state_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic [SW-1:0] grp_cnt_q, grp_cnt_d;
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic done_q, done_d;
    logic [SVW-1:0] sum_q, sum_d;
    logic [VW-1:0] out_q, out_d;
    logic [VW-1:0] res;

    logic adv1;
    logic adv2;
    logic accept;

    assign adv2      = !v2_q || out_ready;
    assign adv1      = !v1_q || adv2;
    assign acc_ready = (state_q == RUN) && adv1;
    assign accept    = acc_valid && acc_ready;

    assign bias_sel  = grp_cnt_q;
    assign out_valid = v2_q;
    assign out_data  = out_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    // Stage 1: sign-extended add, bias captured with the beat it belongs to.
    always_comb begin
        sum_d = sum_q;
        v1_d  = v1_q;
        if (adv1) begin
            v1_d = accept;
            if (accept) begin
                for (int i = 0; i < N_adder_tree; i++) begin
                    sum_d[i*SUMW +: SUMW] =
                        {acc_data[i*DW + DW - 1], acc_data[i*DW +: DW]} +
                        {bias_q[i*DW + DW - 1], bias_q[i*DW +: DW]};
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < N_adder_tree; g++) begin : g_lane
            bias_sat_lane #(
                .DW   (DW),
                .RELU (RELU)
            ) u_lane (
                .sum_i (sum_q[g*SUMW +: SUMW]),
                .res_o (res[g*DW +: DW])
            );
        end
    endgenerate

    // Stage 2: out_data only moves when the stage advances, so it holds
    // steady under backpressure.
    always_comb begin
        v2_d  = v2_q;
        out_d = out_q;
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                out_d = res;
            end
        end
    end

    // done is registered on the edge the pipeline empties so it lands in
    // the cycle after the final output handshake, with busy already low.
    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        grp_cnt_d = grp_cnt_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    pix_cnt_d = '0;
                    grp_cnt_d = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (pix_cnt_q == PIX_LAST) begin
                        pix_cnt_d = '0;
                        if (grp_cnt_q == GRP_LAST) begin
                            grp_cnt_d = '0;
                            state_d   = DRAIN;
                        end else begin
                            grp_cnt_d = grp_cnt_q + SW'(1);
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + PW'(1);
                    end
                end
            end
            DRAIN: begin
                if (!v1_d && !v2_d) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pix_cnt_q <= '0;
            grp_cnt_q <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            done_q    <= 1'b0;
            sum_q     <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            grp_cnt_q <= grp_cnt_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            done_q    <= done_d;
            sum_q     <= sum_d;
            out_q     <= out_d;
        end
    end

endmodule

// File: tb/tb_bias_add_relu.sv
// Randomized self-checking bench for bias_add_relu (RELU=1 and RELU=0 copies).
// Expected outputs come from a plain-integer lane model and a queue.
module tb_bias_add_relu;

    localparam int N   = 4;
    localparam int DW  = 18;
    localparam int PPG = 3;
    localparam int NG  = 2;
    localparam int NB  = PPG * NG;
    localparam int VW  = N * DW;

    localparam logic [VW-1:0] DIRA  =
        {18'h20000, 18'd131000, 18'h3EC78, 18'd1000};
    localparam logic [VW-1:0] DIRB0 =
        {18'h3FE70, 18'h00D14, 18'h00D14, 18'h3FE70};
    localparam logic [VW-1:0] DIR1  =
        {18'h00000, 18'h1FFFF, 18'h00000, 18'd600};
    localparam logic [VW-1:0] DIR0  =
        {18'h20000, 18'h1FFFF, 18'h3F98C, 18'd600};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic acc_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [VW-1:0] acc_data = '0;
    logic [VW-1:0] bias_tbl [NG];

    logic acc_ready1, acc_ready0;
    logic out_valid1, out_valid0;
    logic busy1, busy0, done1, done0;
    logic [0:0] sel1, sel0;
    logic [VW-1:0] bias_q1, bias_q0;
    logic [VW-1:0] out_data1, out_data0;

    assign bias_q1 = bias_tbl[sel1];
    assign bias_q0 = bias_tbl[sel0];

    always #5 clk = ~clk;

    bias_add_relu #(
        .N_adder_tree (N), .DW (DW), .PIX_PER_GROUP (PPG),
        .N_GROUPS (NG), .RELU (1)
    ) u_dut1 (
        .clk (clk), .rst_n (rst_n), .start (start),
        .acc_valid (acc_valid), .acc_ready (acc_ready1),
        .acc_data (acc_data), .bias_q (bias_q1), .bias_sel (sel1),
        .out_valid (out_valid1), .out_ready (out_ready),
        .out_data (out_data1), .busy (busy1), .done (done1)
    );

    bias_add_relu #(
        .N_adder_tree (N), .DW (DW), .PIX_PER_GROUP (PPG),
        .N_GROUPS (NG), .RELU (0)
    ) u_dut0 (
        .clk (clk), .rst_n (rst_n), .start (start),
        .acc_valid (acc_valid), .acc_ready (acc_ready0),
        .acc_data (acc_data), .bias_q (bias_q0), .bias_sel (sel0),
        .out_valid (out_valid0), .out_ready (out_ready),
        .out_data (out_data0), .busy (busy0), .done (done0)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] model(input logic [VW-1:0] a,
                                            input logic [VW-1:0] b,
                                            input bit relu);
        logic [VW-1:0] r;
        logic signed [DW-1:0] x, y;
        int s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            x = a[i*DW +: DW];
            y = b[i*DW +: DW];
            s = int'(x) + int'(y);
            if (s > 131071) s = 131071;
            if (s < -131072) s = -131072;
            if (relu && s < 0) s = 0;
            r[i*DW +: DW] = s[DW-1:0];
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
                0: v = int'($urandom_range(0, 262143));
                1: v = 131071 - int'($urandom_range(0, 4000));
                2: v = -131072 + int'($urandom_range(0, 4000));
                default: v = int'($urandom_range(0, 6000)) - 3000;
            endcase
            r[i*DW +: DW] = v[DW-1:0];
        end
        return r;
    endfunction

    typedef struct {
        logic [VW-1:0] e1;
        logic [VW-1:0] e0;
        int cyc;
    } exp_t;

    exp_t q[$];
    int cyc_g = 0;
    int beats_in = 0;
    int beats_out = 0;
    int done_cnt = 0;
    int last_out_cyc = 0;
    bit prev_stall = 0;
    logic [VW-1:0] prev_data = '0;
    bit lat_chk = 0;
    bit dir_chk = 0;
    bit bp_mode = 0;
    bit saw_drop = 0;

    exp_t m_e;
    int m_g;

    always @(negedge clk) begin
        cyc_g++;
        if (!rst_n) begin
            q.delete();
            beats_in = 0;
            beats_out = 0;
            prev_stall = 0;
        end else begin
            if (start && !busy1) begin
                beats_in = 0;
                beats_out = 0;
                done_cnt = 0;
            end
            if (prev_stall) begin
                check("stall_valid", 128'(out_valid1), 128'(1));
                check("stall_data", 128'(out_data1), 128'(prev_data));
            end
            if (bp_mode && busy1 && acc_valid && !acc_ready1 &&
                beats_in > 0 && beats_in < NB)
                saw_drop = 1;
            if (acc_valid && acc_ready1) begin
                m_g = (beats_in / PPG) % NG;
                check("bias_sel", 128'(sel1), 128'(m_g));
                check("ready_match", 128'(acc_ready0), 128'(1));
                check("inflight", 128'(q.size() <= 2), 128'(1));
                m_e.e1 = model(acc_data, bias_tbl[m_g], 1'b1);
                m_e.e0 = model(acc_data, bias_tbl[m_g], 1'b0);
                m_e.cyc = cyc_g;
                q.push_back(m_e);
                beats_in++;
            end
            if (out_valid1 && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 128'(out_data1), 128'(0));
                end else begin
                    m_e = q.pop_front();
                    check("out_relu", 128'(out_data1), 128'(m_e.e1));
                    check("out_norelu", 128'(out_data0), 128'(m_e.e0));
                    check("valid_match", 128'(out_valid0), 128'(1));
                    if (lat_chk)
                        check("latency", 128'(cyc_g - m_e.cyc), 128'(2));
                    if (dir_chk && beats_out == 0) begin
                        check("dir_relu", 128'(out_data1), 128'(DIR1));
                        check("dir_norelu", 128'(out_data0), 128'(DIR0));
                    end
                end
                beats_out++;
                last_out_cyc = cyc_g;
            end
            if (done1) begin
                done_cnt++;
                check("done_gap", 128'(cyc_g - last_out_cyc), 128'(1));
                check("done_busy", 128'(busy1), 128'(0));
                check("done_outs", 128'(beats_out), 128'(NB));
                check("done_match", 128'(done0), 128'(1));
            end
            prev_stall = out_valid1 && !out_ready;
            prev_data = out_data1;
        end
    end

    function automatic bit oready(input int mode, input int c);
        if (mode == 1) return 1'b1;
        if (mode == 2) return !(c >= 3 && c <= 7);
        return $urandom_range(0, 3) != 0;
    endfunction

    // mode 0 random, 1 directed/latency, 2 backpressure,
    // 3 abort by reset, 4 extra start while running
    task automatic run_pass(input int mode);
        int c;
        int sent;
        bit hs;
        c = 0;
        sent = 0;
        if (mode == 1) begin
            bias_tbl[0] = DIRB0;
            bias_tbl[1] = rnd_vec();
            acc_data = DIRA;
        end else begin
            bias_tbl[0] = rnd_vec();
            bias_tbl[1] = rnd_vec();
            acc_data = rnd_vec();
        end
        lat_chk = (mode == 1);
        dir_chk = (mode == 1);
        bp_mode = (mode == 2);
        saw_drop = 0;
        @(posedge clk); #1;
        start = 1'b1;
        acc_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("ready_after_start", 128'(acc_ready1), 128'(1));
        @(posedge clk); #1;
        while (sent < NB && c < 300) begin
            acc_valid = (mode == 1 || mode == 2) ? 1'b1
                      : ($urandom_range(0, 3) != 0);
            out_ready = oready(mode, c);
            start = (mode == 4 && c == 3);
            @(negedge clk);
            hs = acc_valid && acc_ready1;
            @(posedge clk); #1;
            c++;
            if (hs) begin
                sent++;
                acc_data = rnd_vec();
            end
            if (mode == 3 && sent == 3) begin
                rst_n = 1'b0;
                acc_valid = 1'b0;
                start = 1'b0;
                @(negedge clk);
                check("abort_clear",
                      128'({acc_ready1, out_valid1, busy1, done1,
                            sel1, out_data1}), 128'(0));
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                repeat (4) @(posedge clk);
                #1;
                check("abort_no_done", 128'(done_cnt), 128'(0));
                check("abort_idle", 128'(busy1), 128'(0));
                return;
            end
        end
        check("beats_sent", 128'(sent), 128'(NB));
        acc_valid = 1'b0;
        start = 1'b0;
        while (done_cnt == 0 && c < 400) begin
            out_ready = oready(mode, c);
            @(posedge clk); #1;
            c++;
        end
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("done_once", 128'(done_cnt), 128'(1));
        check("idle_after", 128'(busy1), 128'(0));
        if (mode == 2)
            check("bp_ready_drop", 128'(saw_drop), 128'(1));
    endtask

    initial begin
        bias_tbl[0] = '0;
        bias_tbl[1] = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outs1",
              128'({acc_ready1, out_valid1, busy1, done1, sel1, out_data1}),
              128'(0));
        check("rst_outs0",
              128'({acc_ready0, out_valid0, busy0, done0, sel0, out_data0}),
              128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        acc_valid = 1'b1;
        acc_data = rnd_vec();
        repeat (3) begin
            @(negedge clk);
            check("idle_no_ready", 128'(acc_ready1), 128'(0));
            check("idle_no_out", 128'(out_valid1), 128'(0));
        end
        @(posedge clk); #1;
        acc_valid = 1'b0;
        run_pass(1);
        run_pass(2);
        run_pass(4);
        run_pass(3);
        run_pass(0);
        repeat (8) run_pass(0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
